fifo_pixel_reader: RTL

Drains the 8-bit pixel FIFO and re-emits its contents as a framed valid/ready pixel stream with start-of-frame, end-of-line and end-of-frame markers. Sits directly downstream of the pixel FIFO. Hides the FIFO's one-cycle registered read latency behind a 2-entry output buffer, and stops reading at the frame boundary so pixels of the next frame stay in the FIFO until the next `start`.

---
 rtl/fifo_pixel_reader_pkg.sv | 11 +
 rtl/fifo_pixel_reader_if.sv | 20 ++
 rtl/pix_out_buf.sv | 39 +++
 rtl/fifo_pixel_reader.sv | 82 ++++++++
 4 files changed

// File: rtl/fifo_pixel_reader_pkg.sv
// pixel_stream_pkg: shared pixel stream defaults, FSM state type and width helper.
package pixel_stream_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_IMG_WIDTH  = 640;
  localparam int DEF_IMG_HEIGHT = 480;
  typedef enum logic {IDLE, RUN} state_e;
  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fifo_pixel_reader_if.sv
// fifo_pixel_reader_if: FIFO read port plus framed valid/ready pixel stream.
interface fifo_pixel_reader_if #(parameter int DATA_WIDTH = pixel_stream_pkg::DEF_DATA_WIDTH);
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_sof;
  logic                  m_eol;
  logic                  m_eof;
  modport master (
    output fifo_rd_en, m_data, m_valid, m_sof, m_eol, m_eof,
    input  fifo_rd_data, fifo_empty, m_ready
  );
  modport slave (
    input  fifo_rd_en, m_data, m_valid, m_sof, m_eol, m_eof,
    output fifo_rd_data, fifo_empty, m_ready
  );
endinterface

// File: rtl/pix_out_buf.sv
// pix_out_buf: 2-entry in-order pixel buffer with push/pop, occupancy and head data.
module pix_out_buf #(
  parameter int DATA_WIDTH = pixel_stream_pkg::DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [1:0]            occ,
  output logic [DATA_WIDTH-1:0] head
);
  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [DATA_WIDTH-1:0] mem_d [2];
  logic                  wr_q, wr_d, rd_q, rd_d;
  logic [1:0]            occ_q, occ_d;
  always_comb begin
    mem_d        = mem_q;
    mem_d[wr_q]  = push ? push_data : mem_q[wr_q];
    wr_d         = wr_q ^ push;
    rd_d         = rd_q ^ pop;
    occ_d        = occ_q + 2'(push) - 2'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      occ_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
    end
  end
  assign occ  = occ_q;
  assign head = mem_q[rd_q];
endmodule

// File: rtl/fifo_pixel_reader.sv
// fifo_pixel_reader: drains the pixel FIFO into a framed valid/ready stream, one frame per start.
module fifo_pixel_reader
  import pixel_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 frame_done,
  fifo_pixel_reader_if.master  bus
);
  localparam int FRAME = IMG_WIDTH * IMG_HEIGHT;
  localparam int XW    = cnt_w(IMG_WIDTH);
  localparam int YW    = cnt_w(IMG_HEIGHT);
  localparam int IW    = $clog2(FRAME + 1);
  state_e                state_q, state_d;
  logic                  pend_q, pend_d, done_q, done_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [IW-1:0]         iss_q, iss_d;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] head;
  logic                  valid, pop, rd_en, eol, eof, go, credit_ok;
  pix_out_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (pend_q),
    .pop       (pop),
    .push_data (bus.fifo_rd_data),
    .occ       (occ),
    .head      (head)
  );
  assign valid     = occ != 2'd0;
  assign pop       = valid && bus.m_ready;
  assign go        = state_q == IDLE && start;
  assign eol       = x_q == XW'(IMG_WIDTH - 1);
  assign eof       = eol && y_q == YW'(IMG_HEIGHT - 1);
  // Buffered plus in-flight pixels, net of this cycle's pop, must leave a free slot.
  assign credit_ok = {1'b0, occ} + 3'(pend_q) < 3'd2 + 3'(pop);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      iss_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      x_q     <= x_d;
      y_q     <= y_d;
      iss_q   <= iss_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE ? (start ? RUN : IDLE) : (pop && eof ? IDLE : RUN);
  end
  always_comb begin
    busy   = state_q == RUN;
    rd_en  = busy && !bus.fifo_empty && iss_q < IW'(FRAME) && credit_ok;
    done_d = busy && pop && eof;
  end
  always_comb begin
    pend_d = rd_en;
    iss_d  = go ? '0 : iss_q + IW'(rd_en);
    x_d    = go ? '0 : (pop ? (eol ? '0 : x_q + XW'(1)) : x_q);
    y_d    = go ? '0 : (pop && eol ? (y_q == YW'(IMG_HEIGHT - 1) ? '0 : y_q + YW'(1)) : y_q);
  end
  assign frame_done     = done_q;
  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = valid;
  assign bus.m_data     = head;
  assign bus.m_sof      = valid && x_q == '0 && y_q == '0;
  assign bus.m_eol      = valid && eol;
  assign bus.m_eof      = valid && eof;
endmodule
